// File: rtl/hdmi_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_pkg
// Shared definitions for the HDMI data-island packet path.
//   BCH_POLY          : feedback taps of the 8-bit BCH parity LFSR
//   PACKET_BEATS      : beats per data-island packet
//   HEADER_DATA_BITS  : payload bits of the header packet (ECC follows)
//   SUB_DATA_BITS     : payload bits of each subpacket (ECC follows)
//   unpack_state_t    : packet unpacker FSM states
//   bch_step()        : one-bit LFSR update, shared by every ECC instance
// ---------------------------------------------------------------------------
package hdmi_pkg;

    localparam logic [7:0] BCH_POLY         = 8'h83;
    localparam int         PACKET_BEATS     = 32;
    localparam int         HEADER_DATA_BITS = 24;
    localparam int         SUB_DATA_BITS    = 56;

    // Header carries 1 bit per beat, subpackets 2 bits per beat, so the
    // payload occupies this many leading beats of each packet.
    localparam int HEADER_DATA_BEATS = HEADER_DATA_BITS;
    localparam int SUB_DATA_BEATS    = SUB_DATA_BITS / 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } unpack_state_t;

    // Absorb one data bit into the parity register, LSB-first.
    function automatic logic [7:0] bch_step(input logic [7:0] p, input logic d);
        logic fb;
        fb = d ^ p[0];
        return (p >> 1) ^ (fb ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/hdmi_bch_ecc.sv
// ---------------------------------------------------------------------------
// hdmi_bch_ecc
// One BCH parity LFSR that absorbs BITS_PER_BEAT bits per enabled cycle,
// din[0] first.
//   clk_pixel : clock
//   rst_n     : asynchronous active-low reset, clears the parity
//   clear     : restart from zero; combined with enable, the current bits
//               are absorbed into a zero register (first beat of a packet)
//   enable    : absorb din this cycle
//   din       : data bits for this beat
//   parity    : running parity value
// ---------------------------------------------------------------------------
module hdmi_bch_ecc
    import hdmi_pkg::*;
#(
    parameter int BITS_PER_BEAT = 1
) (
    input  logic                     clk_pixel,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     enable,
    input  logic [BITS_PER_BEAT-1:0] din,
    output logic [7:0]               parity
);

    logic [7:0] seed;
    logic [7:0] parity_next;

    always_comb begin
        seed        = clear ? 8'h00 : parity;
        parity_next = seed;
        for (int i = 0; i < BITS_PER_BEAT; i++) begin
            parity_next = bch_step(parity_next, din[i]);
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 8'h00;
        end else if (enable) begin
            parity <= parity_next;
        end else if (clear) begin
            parity <= 8'h00;
        end
    end

endmodule

// File: rtl/packet_unpacker.sv
// ---------------------------------------------------------------------------
// packet_unpacker
// Reassembles 32-beat HDMI data-island packets from TERC4-decoded beats and
// checks the BCH parity of the header and the four subpackets.
//   AUDIO_BIT_WIDTH : audio sample width downstream (no effect here)
//   clk_pixel       : clock
//   rst_n           : asynchronous active-low reset
//   island_valid    : a data-island beat is present
//   island_start    : first beat of a packet (qualified by island_valid)
//   ch0_bit2        : header bit stream, one bit per beat
//   ch1_data[k]     : subpacket k even bit (2n) for beat n
//   ch2_data[k]     : subpacket k odd bit (2n+1) for beat n
//   header          : payload bits 0..23 of the last completed packet
//   sub[k]          : payload bits 0..55 of subpacket k
//   packet_valid    : one-cycle pulse when header/sub/ECC flags update
//   header_ecc_ok   : header parity matched
//   sub_ecc_ok[k]   : subpacket k parity matched
//   packet_abort    : one-cycle pulse when a partial packet is dropped
//   beat_counter    : index of the next expected beat
// ---------------------------------------------------------------------------
module packet_unpacker
    import hdmi_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        island_valid,
    input  logic        island_start,
    input  logic        ch0_bit2,
    input  logic [3:0]  ch1_data,
    input  logic [3:0]  ch2_data,
    output logic [23:0] header,
    output logic [55:0] sub [3:0],
    output logic        packet_valid,
    output logic        header_ecc_ok,
    output logic [3:0]  sub_ecc_ok,
    output logic        packet_abort,
    output logic [4:0]  beat_counter
);

    localparam int audio_width_unused = AUDIO_BIT_WIDTH;

    localparam logic [4:0] LAST_BEAT    = 5'(PACKET_BEATS - 1);
    localparam logic [4:0] HDR_END_BEAT = 5'(HEADER_DATA_BEATS);
    localparam logic [4:0] SUB_END_BEAT = 5'(SUB_DATA_BEATS);

    unpack_state_t state_q;
    unpack_state_t state_d;
    logic [4:0]    cnt_d;
    logic          done_d;
    logic          abort_d;

    logic          accept;
    logic [4:0]    idx;

    logic [31:0]   hdr_buf;
    logic [31:0]   hdr_now;
    logic [63:0]   sub_buf [4];
    logic [63:0]   sub_now [4];

    logic [7:0]    hdr_par;
    logic [7:0]    sub_par [4];
    logic          lfsr_clear;
    logic          hdr_lfsr_en;
    logic          sub_lfsr_en;

    // A beat is taken when it starts a packet (from any state) or continues
    // one in progress; a start always lands at index 0.
    assign accept = island_valid && (island_start || (state_q == ST_COLLECT));
    assign idx    = island_start ? 5'd0 : beat_counter;

    assign lfsr_clear  = accept && island_start;
    assign hdr_lfsr_en = accept && (idx < HDR_END_BEAT);
    assign sub_lfsr_en = accept && (idx < SUB_END_BEAT);

    // -----------------------------------------------------------------------
    // Next-state / control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = beat_counter;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE behaves as IDLE so a new packet may follow with no gap.
                if (island_valid && island_start) begin
                    state_d = ST_COLLECT;
                    cnt_d   = 5'd1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end
            end
            ST_COLLECT: begin
                if (!island_valid) begin
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = 5'd0;
                end else if (island_start) begin
                    abort_d = 1'b1;
                    state_d = ST_COLLECT;
                    cnt_d   = 5'd1;
                end else if (beat_counter == LAST_BEAT) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d   = beat_counter + 5'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Capture buffers. The *_now view already includes the current beat so
    // the final beat can be judged in the same cycle it is sampled.
    // -----------------------------------------------------------------------
    always_comb begin
        hdr_now = hdr_buf;
        for (int k = 0; k < 4; k++) begin
            sub_now[k] = sub_buf[k];
        end
        if (accept) begin
            hdr_now[idx] = ch0_bit2;
            for (int k = 0; k < 4; k++) begin
                sub_now[k][{idx, 1'b0}] = ch1_data[k];
                sub_now[k][{idx, 1'b1}] = ch2_data[k];
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        hdr_buf <= hdr_now;
        for (int k = 0; k < 4; k++) begin
            sub_buf[k] <= sub_now[k];
        end
    end

    // -----------------------------------------------------------------------
    // Parity generators: one for the header, one per subpacket
    // -----------------------------------------------------------------------
    hdmi_bch_ecc #(
        .BITS_PER_BEAT(1)
    ) u_hdr_ecc (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .clear     (lfsr_clear),
        .enable    (hdr_lfsr_en),
        .din       (ch0_bit2),
        .parity    (hdr_par)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sub_ecc
        hdmi_bch_ecc #(
            .BITS_PER_BEAT(2)
        ) u_sub_ecc (
            .clk_pixel (clk_pixel),
            .rst_n     (rst_n),
            .clear     (lfsr_clear),
            .enable    (sub_lfsr_en),
            .din       ({ch2_data[g], ch1_data[g]}),
            .parity    (sub_par[g])
        );
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            beat_counter  <= 5'd0;
            packet_valid  <= 1'b0;
            packet_abort  <= 1'b0;
            header        <= 24'h0;
            header_ecc_ok <= 1'b0;
            sub_ecc_ok    <= 4'h0;
            for (int k = 0; k < 4; k++) begin
                sub[k] <= 56'h0;
            end
        end else begin
            state_q      <= state_d;
            beat_counter <= cnt_d;
            packet_valid <= done_d;
            packet_abort <= abort_d;
            if (done_d) begin
                header        <= hdr_now[23:0];
                header_ecc_ok <= (hdr_par == hdr_now[31:24]);
                for (int k = 0; k < 4; k++) begin
                    sub[k]        <= sub_now[k][55:0];
                    sub_ecc_ok[k] <= (sub_par[k] == sub_now[k][63:56]);
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_unpacker.sv
// ---------------------------------------------------------------------------
// tb_packet_unpacker
// Directed stimulus for packet_unpacker. A packet-level model predicts every
// output each cycle; literal expectations pin the model on key scenarios.
// ---------------------------------------------------------------------------
module tb_packet_unpacker;

    logic        clk_pixel = 1'b0;
    logic        rst_n = 1'b1;
    logic        island_valid = 1'b0;
    logic        island_start = 1'b0;
    logic        ch0_bit2 = 1'b0;
    logic [3:0]  ch1_data = 4'h0;
    logic [3:0]  ch2_data = 4'h0;
    logic [23:0] header;
    logic [55:0] sub [3:0];
    logic        packet_valid;
    logic        header_ecc_ok;
    logic [3:0]  sub_ecc_ok;
    logic        packet_abort;
    logic [4:0]  beat_counter;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int cycle = 0;
    int pv_cycles [$];
    int abort_count = 0;

    // Packet being transmitted (payload plus ECC bits)
    logic [31:0] pk_hdr;
    logic [63:0] pk_sub [4];

    always #5 clk_pixel = ~clk_pixel;

    packet_unpacker #(.AUDIO_BIT_WIDTH(16)) dut (
        .clk_pixel     (clk_pixel),
        .rst_n         (rst_n),
        .island_valid  (island_valid),
        .island_start  (island_start),
        .ch0_bit2      (ch0_bit2),
        .ch1_data      (ch1_data),
        .ch2_data      (ch2_data),
        .header        (header),
        .sub           (sub),
        .packet_valid  (packet_valid),
        .header_ecc_ok (header_ecc_ok),
        .sub_ecc_ok    (sub_ecc_ok),
        .packet_abort  (packet_abort),
        .beat_counter  (beat_counter)
    );

    function automatic logic [7:0] bch(input logic [63:0] data, input int nbits);
        logic [7:0] p;
        logic       fb;
        p = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            fb = data[i] ^ p[0];
            p  = (p >> 1) ^ (fb ? 8'h83 : 8'h00);
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    logic [31:0] m_hdr;
    logic [63:0] m_sub [4];
    int          m_n;
    bit          m_open;
    logic [23:0] e_header;
    logic [55:0] e_sub [4];
    logic        e_hok;
    logic [3:0]  e_sok;
    logic        e_pv;
    logic        e_ab;
    int          e_cnt;

    task automatic m_store(input int b);
        m_hdr[b] = ch0_bit2;
        for (int k = 0; k < 4; k++) begin
            m_sub[k][2*b]   = ch1_data[k];
            m_sub[k][2*b+1] = ch2_data[k];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_pixel or negedge rst_n);
            if (!rst_n) begin
                m_open = 0; m_n = 0; e_cnt = 0;
                e_pv = 0; e_ab = 0; e_header = '0; e_hok = 0; e_sok = '0;
                for (int k = 0; k < 4; k++) e_sub[k] = '0;
            end else begin
                e_pv = 0;
                e_ab = 0;
                if (island_valid && island_start) begin
                    if (m_open) e_ab = 1;
                    m_open = 1;
                    m_store(0);
                    m_n = 1;
                end else if (m_open) begin
                    if (!island_valid) begin
                        e_ab = 1; m_open = 0; m_n = 0;
                    end else begin
                        m_store(m_n);
                        m_n++;
                        if (m_n == 32) begin
                            e_header = m_hdr[23:0];
                            e_hok    = (bch({40'd0, m_hdr[23:0]}, 24) == m_hdr[31:24]);
                            for (int k = 0; k < 4; k++) begin
                                e_sub[k] = m_sub[k][55:0];
                                e_sok[k] = (bch({8'd0, m_sub[k][55:0]}, 56) == m_sub[k][63:56]);
                            end
                            e_pv = 1; m_open = 0; m_n = 0;
                        end
                    end
                end
                e_cnt = m_n;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk_pixel);
            cycle++;
            #2;
            if (chk_en) begin
                check("header", 64'(header), 64'(e_header));
                for (int k = 0; k < 4; k++)
                    check($sformatf("sub%0d", k), 64'(sub[k]), 64'(e_sub[k]));
                check("header_ecc_ok", 64'(header_ecc_ok), 64'(e_hok));
                check("sub_ecc_ok", 64'(sub_ecc_ok), 64'(e_sok));
                check("packet_valid", 64'(packet_valid), 64'(e_pv));
                check("packet_abort", 64'(packet_abort), 64'(e_ab));
                check("beat_counter", 64'(beat_counter), 64'(e_cnt));
                if (packet_valid) pv_cycles.push_back(cycle);
                if (packet_abort) abort_count++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_pkt(input logic [23:0] h, input logic [55:0] s0, input logic [55:0] s1,
                           input logic [55:0] s2, input logic [55:0] s3);
        logic [55:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        pk_hdr = {bch({40'd0, h}, 24), h};
        for (int k = 0; k < 4; k++) pk_sub[k] = {bch({8'd0, s[k]}, 56), s[k]};
    endtask

    task automatic drive(input logic v, input logic s, input int b);
        @(negedge clk_pixel);
        island_valid = v;
        island_start = s;
        if (b >= 0) begin
            ch0_bit2 = pk_hdr[b];
            for (int k = 0; k < 4; k++) begin
                ch1_data[k] = pk_sub[k][2*b];
                ch2_data[k] = pk_sub[k][2*b+1];
            end
        end else begin
            ch0_bit2 = 1'b0; ch1_data = 4'h0; ch2_data = 4'h0;
        end
    endtask

    task automatic send(input int nbeats);
        for (int b = 0; b < nbeats; b++) drive(1'b1, b == 0, b);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, -1);
    endtask

    task automatic after_edge();
        @(posedge clk_pixel);
        #3;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int aborts_before;
        set_pkt(24'h0, 56'h0, 56'h0, 56'h0, 56'h0);
        #1 rst_n = 1'b0;
        #2 chk_en = 1'b1;
        check("rst_header", 64'(header), 64'h0);
        check("rst_beat_counter", 64'(beat_counter), 64'h0);
        check("rst_packet_valid", 64'(packet_valid), 64'h0);
        check("rst_sub_ecc_ok", 64'(sub_ecc_ok), 64'h0);
        repeat (2) @(negedge clk_pixel);
        rst_n = 1'b1;

        // Beats without island_start in IDLE are ignored
        set_pkt(24'hABCDEF, 56'h1, 56'h2, 56'h3, 56'h4);
        drive(1'b1, 1'b0, 3);
        drive(1'b1, 1'b0, 4);
        after_edge();
        check("idle_ignore_cnt", 64'(beat_counter), 64'h0);

        // Null packet
        set_pkt(24'h0, 56'h0, 56'h0, 56'h0, 56'h0);
        idle(1);
        send(32);
        check("null_pv_early", 64'(packet_valid), 64'h0);
        after_edge();
        check("null_pv", 64'(packet_valid), 64'h1);
        check("null_header", 64'(header), 64'h0);
        check("null_hok", 64'(header_ecc_ok), 64'h1);
        check("null_sok", 64'(sub_ecc_ok), 64'hF);
        check("null_cnt", 64'(beat_counter), 64'h0);

        // Good packet
        set_pkt(24'h0D0282, 56'h12, 56'h0, 56'h0, 56'h0);
        idle(1);
        send(32);
        after_edge();
        check("good_pv", 64'(packet_valid), 64'h1);
        check("good_header", 64'(header), 64'h0D0282);
        check("good_sub0", 64'(sub[0]), 64'h12);
        check("good_hok", 64'(header_ecc_ok), 64'h1);
        check("good_sok", 64'(sub_ecc_ok), 64'hF);

        // Header bit 5 and sub2 ECC bit 60 corrupted
        set_pkt(24'h0D0282, 56'h12, 56'h0, 56'h0, 56'h0);
        pk_hdr[5]     = ~pk_hdr[5];
        pk_sub[2][60] = ~pk_sub[2][60];
        idle(1);
        send(32);
        after_edge();
        check("bad_header", 64'(header), 64'h0D02A2);
        check("bad_hok", 64'(header_ecc_ok), 64'h0);
        check("bad_sok", 64'(sub_ecc_ok), 64'b1011);

        // island_valid dropped at beat 17
        set_pkt(24'h123456, 56'hAA, 56'hBB, 56'hCC, 56'hDD);
        idle(1);
        send(17);
        drive(1'b0, 1'b0, -1);
        after_edge();
        check("drop_abort", 64'(packet_abort), 64'h1);
        check("drop_pv", 64'(packet_valid), 64'h0);
        check("drop_cnt", 64'(beat_counter), 64'h0);
        check("drop_hold_header", 64'(header), 64'h0D02A2);

        // Restart mid-packet with a new island_start
        set_pkt(24'h555555, 56'h1, 56'h1, 56'h1, 56'h1);
        idle(1);
        send(5);
        set_pkt(24'h00BEEF, 56'hFEDCBA98765432, 56'h0123456789ABCD, 56'h0, 56'hFFFFFFFFFFFFFF);
        drive(1'b1, 1'b1, 0);
        after_edge();
        check("restart_abort", 64'(packet_abort), 64'h1);
        check("restart_cnt", 64'(beat_counter), 64'h1);
        for (int b = 1; b < 32; b++) drive(1'b1, 1'b0, b);
        after_edge();
        check("restart_header", 64'(header), 64'h00BEEF);
        check("restart_sub3", 64'(sub[3]), 64'hFFFFFFFFFFFFFF);
        check("restart_flags", 64'({header_ecc_ok, sub_ecc_ok}), 64'h1F);

        // Back-to-back packets, zero gap
        set_pkt(24'h111111, 56'h22, 56'h33, 56'h44, 56'h55);
        idle(1);
        send(32);
        after_edge();
        check("b2b_first_header", 64'(header), 64'h111111);
        set_pkt(24'h987654, 56'h66, 56'h77, 56'h88, 56'h99);
        send(32);
        after_edge();
        check("b2b_second_header", 64'(header), 64'h987654);
        check("b2b_second_sub1", 64'(sub[1]), 64'h77);
        check("b2b_second_flags", 64'({header_ecc_ok, sub_ecc_ok}), 64'h1F);
        if (pv_cycles.size() >= 2)
            check("b2b_spacing", 64'(pv_cycles[pv_cycles.size()-1] - pv_cycles[pv_cycles.size()-2]), 64'd32);
        else
            check("b2b_pulse_count", 64'(pv_cycles.size()), 64'd2);

        // Reset asserted at beat 10
        aborts_before = abort_count;
        set_pkt(24'h777777, 56'h1, 56'h2, 56'h3, 56'h4);
        idle(1);
        send(10);
        @(negedge clk_pixel);
        rst_n = 1'b0;
        island_valid = 1'b0;
        island_start = 1'b0;
        #2;
        check("mid_rst_header", 64'(header), 64'h0);
        check("mid_rst_sub0", 64'(sub[0]), 64'h0);
        check("mid_rst_flags", 64'({header_ecc_ok, sub_ecc_ok}), 64'h0);
        check("mid_rst_cnt", 64'(beat_counter), 64'h0);
        check("mid_rst_pulses", 64'({packet_valid, packet_abort}), 64'h0);
        repeat (2) @(negedge clk_pixel);
        rst_n = 1'b1;
        set_pkt(24'h0A0B0C, 56'h0D, 56'h0E, 56'h0F, 56'h10);
        send(32);
        after_edge();
        check("post_rst_header", 64'(header), 64'h0A0B0C);
        check("post_rst_sub2", 64'(sub[2]), 64'h0F);
        check("post_rst_flags", 64'({header_ecc_ok, sub_ecc_ok}), 64'h1F);
        check("post_rst_no_abort", 64'(abort_count), 64'(aborts_before));

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
